// File: rtl/encoder_pkg.sv
// Shared encoder definitions: quadrature channel encoding and default counts per revolution.
// Used by the emulator and by the encoder counter blocks.
package encoder_pkg;

  localparam int CPR_DEFAULT = 1024;

  // {A,B} for each value of pos[1:0]; successive states differ in exactly one bit.
  typedef enum logic [1:0] {
    QUAD_S0 = 2'b00,
    QUAD_S1 = 2'b10,
    QUAD_S2 = 2'b11,
    QUAD_S3 = 2'b01
  } quad_state_t;

  function automatic quad_state_t quad_encode(input logic [1:0] phase);
    quad_state_t s;
    unique case (phase)
      2'd0: s = QUAD_S0;
      2'd1: s = QUAD_S1;
      2'd2: s = QUAD_S2;
      2'd3: s = QUAD_S3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_step_timer.sv
// Interval timer for the encoder emulator: latches the period at interval boundaries
// and raises tick (combinational) in the last cycle of each interval.
module quad_step_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clr,
  input  logic [7:0] speed,
  output logic       tick
);

  logic [7:0] timer;
  logic [7:0] period_q;
  logic [7:0] eff_period;
  logic       run;
  logic       last;

  // At an interval boundary the fresh speed value is the period in force, so a
  // newly requested rate starts counting in the very cycle it is sampled.
  always_comb begin
    eff_period = (timer == 8'd0) ? speed : period_q;
    run        = enable && (eff_period != 8'd0);
    last       = (timer == eff_period - 8'd1);
    tick       = run && last && !clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= 8'd0;
      period_q <= 8'd0;
    end else begin
      if (timer == 8'd0) period_q <= speed;
      if (clr || !run || last) timer <= 8'd0;
      else                     timer <= timer + 8'd1;
    end
  end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: steps a position at a programmable rate and drives
// registered A/B/index channels plus a one-cycle step strobe.
module quad_encoder_emulator
  import encoder_pkg::*;
#(
  parameter int CPR = CPR_DEFAULT,
  parameter int PW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [7:0]    speed,
  input  logic          dir,
  input  logic          zero,
  output logic          cha,
  output logic          chb,
  output logic          idx,
  output logic [PW-1:0] pos,
  output logic          step
);

  localparam logic [PW-1:0] POS_LAST = PW'(CPR - 1);

  logic          tick;
  logic [PW-1:0] next_pos;

  quad_step_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clr    (zero),
    .speed  (speed),
    .tick   (tick)
  );

  // Modular step with explicit wrap so CPR need not be a power of two.
  always_comb begin
    next_pos = pos;
    if (dir) next_pos = (pos == POS_LAST) ? '0 : pos + PW'(1);
    else     next_pos = (pos == '0) ? POS_LAST : pos - PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos  <= '0;
      cha  <= 1'b0;
      chb  <= 1'b0;
      idx  <= 1'b1;
      step <= 1'b0;
    end else begin
      step <= 1'b0;
      if (zero) begin
        pos        <= '0;
        {cha, chb} <= QUAD_S0;
        idx        <= 1'b1;
      end else if (tick) begin
        pos        <= next_pos;
        {cha, chb} <= quad_encode(next_pos[1:0]);
        idx        <= (next_pos == '0);
        step       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench for quad_encoder_emulator: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_quad_encoder_emulator;

  localparam int CPR = 8;
  localparam int PW  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic [7:0]    speed  = 8'd0;
  logic          dir    = 1'b1;
  logic          zero   = 1'b0;
  logic          cha, chb, idx, step;
  logic [PW-1:0] pos;

  quad_encoder_emulator #(.CPR(CPR), .PW(PW)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .speed  (speed),
    .dir    (dir),
    .zero   (zero),
    .cha    (cha),
    .chb    (chb),
    .idx    (idx),
    .pos    (pos),
    .step   (step)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: elapsed cycles within the current interval, and the
  // interval length chosen when that interval began.
  int   m_pos   = 0;
  int   m_phase = 0;
  int   m_len   = 0;
  logic m_step  = 1'b0;
  logic [1:0] ab_of_pos [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always @(posedge clk or posedge rst) begin
    int len;
    if (rst) begin
      m_pos = 0; m_phase = 0; m_len = 0; m_step = 1'b0;
    end else begin
      len = (m_phase == 0) ? int'(speed) : m_len;
      if (m_phase == 0) m_len = int'(speed);
      m_step = 1'b0;
      if (zero) begin
        m_pos = 0; m_phase = 0;
      end else if (!enable || len == 0) begin
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
        if (m_phase == len) begin
          m_phase = 0;
          m_step  = 1'b1;
          m_pos   = dir ? (m_pos + 1) % CPR : (m_pos + CPR - 1) % CPR;
        end
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("model_pos", int'(pos), m_pos);
      check("model_ab", int'({cha, chb}), int'(ab_of_pos[m_pos % 4]));
      check("model_idx", int'(idx), int'(m_pos == 0));
      check("model_step", int'(step), int'(m_step));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_outputs(input string name, input int p, input int ab, input int ix, input int st);
    check({name, "_pos"}, int'(pos), p);
    check({name, "_ab"}, int'({cha, chb}), ab);
    check({name, "_idx"}, int'(idx), ix);
    check({name, "_step"}, int'(step), st);
  endtask

  logic [1:0] seq_ab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  int n_steps;

  initial begin
    repeat (3) tick();
    check_outputs("reset", 0, 0, 1, 0);
    rst = 1'b0;

    // steady rate 4 forward: first step 4 cycles after enable
    enable = 1'b1; speed = 8'd4; dir = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("rate4_step", int'(step), int'(k % 4 == 0));
      if (k % 4 == 0) begin
        check("rate4_pos", int'(pos), k / 4);
        check("rate4_ab", int'({cha, chb}), int'(seq_ab[k / 4 - 1]));
      end
    end

    // clear then one step per cycle: wrap forward, then reverse through 0
    zero = 1'b1; speed = 8'd1;
    tick();
    check_outputs("zero", 0, 0, 1, 0);
    zero = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("wrap_pos", int'(pos), k % 8);
      check("wrap_idx", int'(idx), int'(k % 8 == 0));
    end
    dir = 1'b0;
    tick();
    check_outputs("rev_wrap", 7, 1, 0, 1);
    tick();
    check("rev_pos6", int'(pos), 6);
    tick();
    check("rev_pos5", int'(pos), 5);

    // zero coincident with a step cycle at pos 5
    zero = 1'b1;
    tick();
    check_outputs("zero_vs_step", 0, 0, 1, 0);
    zero = 1'b0;

    // rate change 10 -> 2 at timer 3: current interval still takes 10
    enable = 1'b0; tick();
    enable = 1'b1; speed = 8'd10; dir = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3) speed = 8'd2;
      check("rate_change_step", int'(step), int'(k == 10 || k == 12 || k == 14));
    end
    check("rate_change_pos", int'(pos), 3);

    // dir only matters in the step cycle
    speed = 8'd6;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 6) check("dir_mid_pos_a", int'(pos), 2);
      if (k == 12) check("dir_mid_pos_b", int'(pos), 3);
      case (k)
        2: dir = 1'b0;
        4: dir = 1'b1;
        5: dir = 1'b0;
        7: dir = 1'b1;
        9: dir = 1'b0;
        11: dir = 1'b1;
        default: ;
      endcase
    end

    // stopped by speed 0, then by enable low
    speed = 8'd0; n_steps = 0;
    for (int k = 0; k < 50; k++) begin tick(); n_steps += int'(step); end
    check("speed0_steps", n_steps, 0);
    check("speed0_pos", int'(pos), 3);
    speed = 8'd3; enable = 1'b0; n_steps = 0;
    for (int k = 0; k < 50; k++) begin tick(); n_steps += int'(step); end
    check("disabled_steps", n_steps, 0);
    check("disabled_pos", int'(pos), 3);

    // async reset mid-interval, then restart from a clean interval
    enable = 1'b1; speed = 8'd5;
    tick(); tick();
    #1 rst = 1'b1;
    #1 check_outputs("async_rst", 0, 0, 1, 0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("post_rst_step", int'(step), int'(k == 5));
    end
    check("post_rst_pos", int'(pos), 1);

    // randomized traffic, checked by the model
    for (int k = 0; k < 400; k++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) speed = 8'($urandom_range(0, 6));
      dir  = 1'($urandom_range(0, 1));
      zero = ($urandom_range(0, 30) == 0);
      tick();
    end
    zero = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_emulator.md
QUAD_ENCODER_EMULATOR -- requirements
Module: quad_encoder_emulator

Interface
REQ-001 SHALL have parameter CPR, default 1024, meaning counts per revolution (quadrature edges); it must be a multiple of 4 and at least 8.
REQ-002 SHALL have parameter PW, default 16, meaning the width of pos; 2^PW must be at least CPR.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: run request; when low, stepping is frozen.
REQ-006 SHALL have port speed, input, 8 bits: clk cycles per quadrature edge; 0 means stopped.
REQ-007 SHALL have port dir, input, 1 bit: 1 is forward (A leads B), 0 is reverse.
REQ-008 SHALL have port zero, input, 1 bit: synchronous position clear.
REQ-009 SHALL have port cha, output, 1 bit: encoder channel A.
REQ-010 SHALL have port chb, output, 1 bit: encoder channel B.
REQ-011 SHALL have port idx, output, 1 bit: index, high while pos==0.
REQ-012 SHALL have port pos, output, PW bits: emulated position, 0..CPR-1.
REQ-013 SHALL have port step, output, 1 bit: one-cycle pulse on each quadrature edge.

Function
REQ-014 SHALL hold an interval timer (8 bits) and a latched period period_q (8 bits).
REQ-015 SHALL load period_q from speed in every cycle where the timer is 0; speed changes take effect only at interval boundaries.
REQ-016 SHALL, with enable=1 and period_q=N≥1, count the timer 0..N-1 and, in the cycle timer==N-1, step once and return the timer to 0. One edge occurs per N cycles; with N=1, one edge per cycle.
REQ-017 SHALL, when period_q==0 or enable==0, hold the timer at 0 and generate no steps. Re-enabling produces the first step N cycles after enable is sampled high.
REQ-018 SHALL sample dir only in the step cycle; dir changes mid-interval have no effect until the next step.
REQ-019 SHALL step pos forward as (pos+1) mod CPR and reverse as (pos-1) mod CPR: CPR-1 wraps to 0 forward, and 0 wraps to CPR-1 reverse.
REQ-020 SHALL drive {cha,chb} as a registered function of pos[1:0]: 0->00, 1->10, 2->11, 3->01. Exactly one channel toggles per step.
REQ-021 SHALL drive idx, registered, equal to (pos==0), updated in the same cycle as pos.
REQ-022 SHALL pulse step high for exactly the one cycle in which pos/cha/chb update.
REQ-023 SHALL, when zero=1, set pos=0 next cycle and reset the timer to 0. Zero wins over a simultaneous step, and step stays low that cycle.
REQ-024 SHALL keep cha, chb, idx, pos and step glitch-free; all come directly from flops.

Reset
REQ-025 SHALL, on rst asserted, asynchronously force pos=0, timer=0, period_q=0, cha=0, chb=0, idx=1, step=0.
REQ-026 SHALL, after rst deasserts, resume per REQ-015..017; rst mid-interval discards any partial interval.

Structure
REQ-027 SHALL take the quadrature state encoding (00, 10, 11, 01) and the default CPR from a shared package encoder_pkg, also used by the encoder counter blocks.
REQ-028 SHALL contain one sub-module, quad_step_timer (timer, period_q, step strobe). Position and output logic are inline.

Verification
REQ-029 SHALL cover: rst, then enable=1, speed=4, dir=1 -> step every 4 cycles, first step 4 cycles after enable; {cha,chb} sequence 10,11,01,00; pos 1,2,3,4.
REQ-030 SHALL cover: CPR=8, speed=1, dir=1 for 8 cycles -> pos wraps 7->0, idx high exactly in the pos==0 cycles; then dir=0 -> pos 0->7, idx drops.
REQ-031 SHALL cover: speed changed 10->2 at timer=3 -> current interval completes at 10 cycles, then steps every 2 cycles.
REQ-032 SHALL cover: zero=1 coincident with a step cycle at pos=5 -> pos=0, step=0, idx=1, {cha,chb}=00.
REQ-033 SHALL cover: speed=0 or enable=0 for 50 cycles -> no steps, outputs stable; rst pulse mid-interval -> all outputs at REQ-025 values immediately, without waiting for clk.
REQ-034 SHALL cover: the dir toggled mid-interval -> direction of the next step follows dir sampled in the step cycle only.
